// File: rtl/alu_exec_pipe_if.sv
// Instruction and result handshake bundle for alu_exec_pipe.
// The master side issues instructions and consumes result beats.
// The slave side is the execute pipeline.
interface alu_exec_pipe_if #(
   parameter int WIDTH = 8,
   parameter int NREGS = 8
);
   localparam int AW = $clog2(NREGS);

   // instruction side
   logic             instr_valid;
   logic             instr_ready;
   logic [3:0]       opcode;
   logic [AW-1:0]    rd;
   logic [AW-1:0]    rs;
   logic [AW-1:0]    rt;
   logic [WIDTH-1:0] imm;

   // result side
   logic             result_valid;
   logic             result_ready;
   logic [WIDTH-1:0] result_out;
   logic [AW-1:0]    result_rd;
   logic             result_wr;
   logic             carry_out;
   logic             zero_out;

   modport master (
      output instr_valid, opcode, rd, rs, rt, imm, result_ready,
      input  instr_ready, result_valid, result_out, result_rd, result_wr,
             carry_out, zero_out
   );

   modport slave (
      input  instr_valid, opcode, rd, rs, rt, imm, result_ready,
      output instr_ready, result_valid, result_out, result_rd, result_wr,
             carry_out, zero_out
   );
endinterface

// File: rtl/alu_exec_pipe.sv
// Two-stage issue/execute ALU pipeline with an NREGS x WIDTH register file.
// Stage 1 latches the instruction; stage 2 reads operands, computes, writes
// back and presents a registered result beat with carry and zero flags.
// Operands are read at execute time, so dependent back-to-back instructions
// see the previous write without any forwarding path.
module alu_exec_pipe #(
   parameter int WIDTH = 8,
   parameter int NREGS = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   alu_exec_pipe_if.slave             bus,
   input  logic [$clog2(NREGS)-1:0]   dbg_addr,
   output logic [WIDTH-1:0]           dbg_data
);
   localparam int AW = $clog2(NREGS);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_LDI = 4'd8;
   localparam logic [3:0] OP_ADC = 4'd9;
   localparam logic [3:0] OP_SBB = 4'd10;
   localparam logic [3:0] OP_CMP = 4'd11;

   // stage 1 state
   logic             s1_valid_r;
   logic [3:0]       s1_op_r;
   logic [AW-1:0]    s1_rd_r;
   logic [AW-1:0]    s1_rs_r;
   logic [AW-1:0]    s1_rt_r;
   logic [WIDTH-1:0] s1_imm_r;

   // stage 2 / result state
   logic             result_valid_r;
   logic [WIDTH-1:0] result_out_r;
   logic [AW-1:0]    result_rd_r;
   logic             result_wr_r;
   logic             carry_r;
   logic             zero_r;

   logic [WIDTH-1:0] regs_r [NREGS];

   // handshake and datapath
   logic             s2_free_s;
   logic             accept_s;
   logic             exec_s;
   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_s;
   logic [WIDTH:0]   cin_s;
   logic [WIDTH:0]   wide_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             alu_c_s;
   logic             wr_s;
   logic             upd_z_s;

   assign s2_free_s       = !result_valid_r || bus.result_ready;
   assign bus.instr_ready = !s1_valid_r || s2_free_s;
   assign accept_s        = bus.instr_valid && bus.instr_ready;
   assign exec_s          = s1_valid_r && s2_free_s;

   assign a_s   = regs_r[s1_rs_r];
   assign b_s   = regs_r[s1_rt_r];
   assign cin_s = {{WIDTH{1'b0}}, carry_r};

   assign bus.result_valid = result_valid_r;
   assign bus.result_out   = result_out_r;
   assign bus.result_rd    = result_rd_r;
   assign bus.result_wr    = result_wr_r;
   assign bus.carry_out    = carry_r;
   assign bus.zero_out     = zero_r;

   assign dbg_data = regs_r[dbg_addr];

   // Issue stage: capture an accepted instruction, drain when it executes.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_op_r    <= 4'd0;
         s1_rd_r    <= {AW{1'b0}};
         s1_rs_r    <= {AW{1'b0}};
         s1_rt_r    <= {AW{1'b0}};
         s1_imm_r   <= {WIDTH{1'b0}};
      end else if (accept_s) begin
         s1_valid_r <= 1'b1;
         s1_op_r    <= bus.opcode;
         s1_rd_r    <= bus.rd;
         s1_rs_r    <= bus.rs;
         s1_rt_r    <= bus.rt;
         s1_imm_r   <= bus.imm;
      end else if (exec_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // ALU: result, next carry, write-enable and zero-update per opcode.
   always_comb begin
      wide_s    = {(WIDTH+1){1'b0}};
      alu_res_s = {WIDTH{1'b0}};
      alu_c_s   = carry_r;
      wr_s      = 1'b0;
      upd_z_s   = 1'b1;
      case (s1_op_r)
         OP_ADD: begin
            wide_s    = {1'b0, a_s} + {1'b0, b_s};
            alu_res_s = wide_s[WIDTH-1:0];
            alu_c_s   = wide_s[WIDTH];
            wr_s      = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            wide_s    = {1'b0, a_s} - {1'b0, b_s};
            alu_res_s = wide_s[WIDTH-1:0];
            alu_c_s   = wide_s[WIDTH];
            wr_s      = (s1_op_r == OP_SUB);
         end
         OP_AND: begin
            alu_res_s = a_s & b_s;
            alu_c_s   = 1'b0;
            wr_s      = 1'b1;
         end
         OP_OR: begin
            alu_res_s = a_s | b_s;
            alu_c_s   = 1'b0;
            wr_s      = 1'b1;
         end
         OP_XOR: begin
            alu_res_s = a_s ^ b_s;
            alu_c_s   = 1'b0;
            wr_s      = 1'b1;
         end
         OP_NOT: begin
            alu_res_s = ~a_s;
            alu_c_s   = 1'b0;
            wr_s      = 1'b1;
         end
         OP_SHL: begin
            alu_res_s = {a_s[WIDTH-2:0], 1'b0};
            alu_c_s   = a_s[WIDTH-1];
            wr_s      = 1'b1;
         end
         OP_SHR: begin
            alu_res_s = {1'b0, a_s[WIDTH-1:1]};
            alu_c_s   = a_s[0];
            wr_s      = 1'b1;
         end
         OP_LDI: begin
            alu_res_s = s1_imm_r;
            wr_s      = 1'b1;
         end
         OP_ADC: begin
            wide_s    = {1'b0, a_s} + {1'b0, b_s} + cin_s;
            alu_res_s = wide_s[WIDTH-1:0];
            alu_c_s   = wide_s[WIDTH];
            wr_s      = 1'b1;
         end
         OP_SBB: begin
            // The (WIDTH+1)-bit difference is negative exactly when A < B+c.
            wide_s    = {1'b0, a_s} - {1'b0, b_s} - cin_s;
            alu_res_s = wide_s[WIDTH-1:0];
            alu_c_s   = wide_s[WIDTH];
            wr_s      = 1'b1;
         end
         default: begin
            // NOP: empty beat, flags untouched
            upd_z_s = 1'b0;
         end
      endcase
   end

   // Execute stage: register the result beat and flags, hold under stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_valid_r <= 1'b0;
         result_out_r   <= {WIDTH{1'b0}};
         result_rd_r    <= {AW{1'b0}};
         result_wr_r    <= 1'b0;
         carry_r        <= 1'b0;
         zero_r         <= 1'b0;
      end else if (exec_s) begin
         result_valid_r <= 1'b1;
         result_out_r   <= alu_res_s;
         result_rd_r    <= s1_rd_r;
         result_wr_r    <= wr_s;
         carry_r        <= alu_c_s;
         if (upd_z_s) begin
            zero_r <= (alu_res_s == {WIDTH{1'b0}});
         end else begin
            zero_r <= zero_r;
         end
      end else if (bus.result_ready) begin
         result_valid_r <= 1'b0;
      end
   end

   // Register file: cleared on reset, written at execute for writing ops.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {WIDTH{1'b0}};
         end
      end else if (exec_s && wr_s) begin
         regs_r[s1_rd_r] <= alu_res_s;
      end
   end
endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed self-checking bench for alu_exec_pipe (WIDTH=8, NREGS=8).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_alu_exec_pipe;
   logic       clk;
   logic       rst;
   logic [2:0] dbg_addr;
   logic [7:0] dbg_data;
   int         errors = 0;
   int         checks = 0;

   alu_exec_pipe_if #(.WIDTH(8), .NREGS(8)) bus ();

   alu_exec_pipe #(.WIDTH(8), .NREGS(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {result_valid, result_wr, result_rd, carry_out, zero_out, result_out}
   function automatic logic [14:0] obs();
      return {bus.result_valid, bus.result_wr, bus.result_rd,
              bus.carry_out, bus.zero_out, bus.result_out};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [2:0] d,
                        input logic [2:0] s, input logic [2:0] t,
                        input logic [7:0] im);
      bus.instr_valid = 1'b1;
      bus.opcode      = op;
      bus.rd          = d;
      bus.rs          = s;
      bus.rt          = t;
      bus.imm         = im;
   endtask

   // accept at one edge, execute at the next; result visible afterwards
   task automatic issue(input logic [3:0] op, input logic [2:0] d,
                        input logic [2:0] s, input logic [2:0] t,
                        input logic [7:0] im);
      drive(op, d, s, t, im);
      step();
      bus.instr_valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.instr_valid  = 1'b0;
      bus.result_ready = 1'b1;
      bus.opcode = 4'd0; bus.rd = 3'd0; bus.rs = 3'd0; bus.rt = 3'd0;
      bus.imm = 8'h00;
      dbg_addr = 3'd0;
      step();
      step();
      rst = 1'b0;
      checks++;
      if (obs() !== 15'h0000) begin
         errors++; $display("FAIL reset_state got %h exp %h", obs(), 15'h0000);
      end
      checks++;
      if (bus.instr_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b exp 1", bus.instr_ready);
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         checks++;
         if (dbg_data !== 8'h00) begin
            errors++; $display("FAIL reset_reg%0d got %h exp 00", i, dbg_data);
         end
      end
   endtask

   task automatic test_add();
      issue(4'd8, 3'd1, 3'd0, 3'd0, 8'hF0);
      checks++;
      if (obs() !== {1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 8'hF0}) begin
         errors++; $display("FAIL ldi_r1 got %h exp %h", obs(), {1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 8'hF0});
      end
      issue(4'd8, 3'd2, 3'd0, 3'd0, 8'h20);
      checks++;
      if (obs() !== {1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 8'h20}) begin
         errors++; $display("FAIL ldi_r2 got %h exp %h", obs(), {1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 8'h20});
      end
      issue(4'd0, 3'd3, 3'd1, 3'd2, 8'h00);
      checks++;
      if (obs() !== {1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'h10}) begin
         errors++; $display("FAIL add_carry got %h exp %h", obs(), {1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'h10});
      end
      dbg_addr = 3'd3;
      #1;
      checks++;
      if (dbg_data !== 8'h10) begin
         errors++; $display("FAIL dbg_r3 got %h exp 10", dbg_data);
      end
   endtask

   task automatic test_chain();
      issue(4'd9, 3'd4, 3'd1, 3'd2, 8'h00);
      checks++;
      if (obs() !== {1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 8'h11}) begin
         errors++; $display("FAIL adc got %h exp %h", obs(), {1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 8'h11});
      end
      issue(4'd10, 3'd5, 3'd0, 3'd0, 8'h00);
      checks++;
      if (obs() !== {1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 8'hFF}) begin
         errors++; $display("FAIL sbb got %h exp %h", obs(), {1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 8'hFF});
      end
   endtask

   task automatic test_ops();
      logic [3:0] op_t  [7] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1};
      logic [7:0] res_t [7] = '{8'h24, 8'hBD, 8'h99, 8'h5A, 8'h4A, 8'h52, 8'h69};
      logic       c_t   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      issue(4'd8, 3'd1, 3'd0, 3'd0, 8'hA5);
      issue(4'd8, 3'd2, 3'd0, 3'd0, 8'h3C);
      for (int i = 0; i < 7; i++) begin
         issue(op_t[i], 3'd6, 3'd1, 3'd2, 8'h00);
         checks++;
         if (obs() !== {1'b1, 1'b1, 3'd6, c_t[i], 1'b0, res_t[i]}) begin
            errors++; $display("FAIL op%0d got %h exp %h", op_t[i], obs(), {1'b1, 1'b1, 3'd6, c_t[i], 1'b0, res_t[i]});
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_t [3] = '{8'h05, 8'h0A, 8'h14};
      drive(4'd8, 3'd1, 3'd0, 3'd0, 8'h05);
      step();
      drive(4'd0, 3'd1, 3'd1, 3'd1, 8'h00);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) bus.instr_valid = 1'b0;
         step();
         checks++;
         if (obs() !== {1'b1, 1'b1, 3'd1, 1'b0, 1'b0, exp_t[i]}) begin
            errors++; $display("FAIL b2b_beat%0d got %h exp %h", i, obs(), {1'b1, 1'b1, 3'd1, 1'b0, 1'b0, exp_t[i]});
         end
      end
      step();
      checks++;
      if (bus.result_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_drain got %b exp 0", bus.result_valid);
      end
   endtask

   task automatic test_backpressure();
      bus.result_ready = 1'b0;
      drive(4'd8, 3'd6, 3'd0, 3'd0, 8'h11);
      step();
      checks++;
      if (bus.result_valid !== 1'b0) begin
         errors++; $display("FAIL bp_first got %b exp 0", bus.result_valid);
      end
      drive(4'd8, 3'd7, 3'd0, 3'd0, 8'h22);
      step();
      drive(4'd8, 3'd5, 3'd0, 3'd0, 8'h33);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({bus.instr_ready, obs()} !== {1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 8'h11}) begin
            errors++; $display("FAIL bp_stall%0d got %h exp %h", i, {bus.instr_ready, obs()}, {1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 8'h11});
         end
         if (i < 2) step();
      end
      bus.result_ready = 1'b1;
      #1;
      checks++;
      if (bus.instr_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release_ready got %b exp 1", bus.instr_ready);
      end
      step();
      bus.instr_valid = 1'b0;
      checks++;
      if (obs() !== {1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 8'h22}) begin
         errors++; $display("FAIL bp_second got %h exp %h", obs(), {1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 8'h22});
      end
      step();
      checks++;
      if (obs() !== {1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'h33}) begin
         errors++; $display("FAIL bp_third got %h exp %h", obs(), {1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'h33});
      end
      step();
      checks++;
      if (bus.result_valid !== 1'b0) begin
         errors++; $display("FAIL bp_no_dup got %b exp 0", bus.result_valid);
      end
   endtask

   task automatic test_cmp_nop();
      issue(4'd8, 3'd1, 3'd0, 3'd0, 8'h07);
      issue(4'd8, 3'd2, 3'd0, 3'd0, 8'h07);
      issue(4'd11, 3'd1, 3'd1, 3'd2, 8'h00);
      checks++;
      if (obs() !== {1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 8'h00}) begin
         errors++; $display("FAIL cmp got %h exp %h", obs(), {1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 8'h00});
      end
      dbg_addr = 3'd1;
      #1;
      checks++;
      if (dbg_data !== 8'h07) begin
         errors++; $display("FAIL cmp_r1_kept got %h exp 07", dbg_data);
      end
      issue(4'd12, 3'd3, 3'd1, 3'd2, 8'h00);
      checks++;
      if (obs() !== {1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 8'h00}) begin
         errors++; $display("FAIL nop_after_cmp got %h exp %h", obs(), {1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 8'h00});
      end
      issue(4'd1, 3'd3, 3'd0, 3'd1, 8'h00);
      checks++;
      if (obs() !== {1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'hF9}) begin
         errors++; $display("FAIL sub_borrow got %h exp %h", obs(), {1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'hF9});
      end
      issue(4'd15, 3'd2, 3'd1, 3'd1, 8'h00);
      checks++;
      if (obs() !== {1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 8'h00}) begin
         errors++; $display("FAIL nop_after_sub got %h exp %h", obs(), {1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 8'h00});
      end
      dbg_addr = 3'd2;
      #1;
      checks++;
      if (dbg_data !== 8'h07) begin
         errors++; $display("FAIL nop_r2_kept got %h exp 07", dbg_data);
      end
   endtask

   task automatic test_reset_mid();
      bus.result_ready = 1'b0;
      drive(4'd8, 3'd4, 3'd0, 3'd0, 8'hFF);
      step();
      drive(4'd0, 3'd5, 3'd4, 3'd4, 8'h00);
      step();
      checks++;
      if ({bus.instr_ready, bus.result_valid, bus.carry_out} !== 3'b011) begin
         errors++; $display("FAIL mid_full got %b exp 011", {bus.instr_ready, bus.result_valid, bus.carry_out});
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.instr_valid = 1'b0;
      bus.result_ready = 1'b1;
      checks++;
      if ({bus.instr_ready, obs()} !== {1'b1, 15'h0000}) begin
         errors++; $display("FAIL mid_reset got %h exp %h", {bus.instr_ready, obs()}, {1'b1, 15'h0000});
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         checks++;
         if (dbg_data !== 8'h00) begin
            errors++; $display("FAIL mid_reg%0d got %h exp 00", i, dbg_data);
         end
      end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (bus.result_valid !== 1'b0) begin
            errors++; $display("FAIL mid_discard%0d got %b exp 0", i, bus.result_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_chain();
      test_ops();
      test_back_to_back();
      test_backpressure();
      test_cmp_nop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_exec_pipe.md
Name: alu_exec_pipe

Overview:
- Parametrised successor to the 8-bit ALU/control/register datapath.
- Combines a 4-bit opcode decoder, a WIDTH-bit ALU with carry and zero flags, and an NREGS-entry register file addressed by rd/rs/rt.
- Two-stage issue/execute pipeline with valid/ready handshakes on both the instruction and result sides.
- Sits between the instruction fetch/sequencer and downstream result consumers.

Parameters:
- WIDTH, 8, datapath and register width (>=4).
- NREGS, 8, register file depth; power of two, >=2. AW = clog2(NREGS) is a derived localparam.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction present.
- instr_ready  output  1  block can accept an instruction this cycle.
- opcode  input  4  operation select (see Behaviour).
- rd  input  AW  destination register.
- rs  input  AW  operand A register.
- rt  input  AW  operand B register.
- imm  input  WIDTH  immediate for LDI.
- result_valid  output  1  result beat present.
- result_ready  input  1  consumer accepts result.
- result_out  output  WIDTH  ALU result.
- result_rd  output  AW  destination of the result beat.
- result_wr  output  1  beat wrote the register file.
- carry_out  output  1  carry/borrow flag register.
- zero_out  output  1  zero flag register.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  WIDTH  combinational regs[dbg_addr].

Behaviour:
- Reset: one rst cycle clears s1_valid, result_valid, result_out, result_rd, result_wr, carry_out, zero_out and all registers to 0. In-flight instructions are discarded. rst overrides all handshakes in the same cycle.
- Stage 1 (issue): on instr_valid && instr_ready, latch opcode, rd, rs, rt and imm; set s1_valid.
- Handshake signals:
  - s2_free = !result_valid || result_ready.
  - instr_ready = !s1_valid || s2_free (combinational; must not depend on instr_valid).
- Stage 2 (execute), when s1_valid && s2_free, at that edge:
  - read A = regs[rs] and B = regs[rt] combinationally, compute, and register result_out, result_rd, result_wr and the flags;
  - write regs[rd] if the op writes;
  - set result_valid.
  - Otherwise, if result_ready, clear result_valid.
  - Operands are read at execute, so back-to-back dependent instructions need no forwarding.
- Latency and throughput: a result appears the cycle after acceptance; throughput is 1 per cycle.
- Stall: with result_valid && !result_ready, result_out, result_rd, result_wr and both flags hold stable. S1 holds; instr_ready = !s1_valid.
- Ops (arithmetic is modulo 2^WIDTH, carry is bit WIDTH):

  | Opcode | Op | Result | Carry |
  |---|---|---|---|
  | 0 | ADD | A+B | carry out |
  | 1 | SUB | A-B | borrow = (A<B) |
  | 2 | AND | A&B | cleared |
  | 3 | OR | A\|B | cleared |
  | 4 | XOR | A^B | cleared |
  | 5 | NOT | ~A | cleared |
  | 6 | SHL | A<<1 | A[WIDTH-1] |
  | 7 | SHR | A>>1 logical | A[0] |
  | 8 | LDI | imm | unchanged |
  | 9 | ADC | A+B+carry_out | carry out |
  | 10 | SBB | A-B-carry_out | borrow = (A < B+carry_out), evaluated WIDTH+1 bits wide |
  | 11 | CMP | A-B | as SUB |
  | 12-15 | NOP | 0 | unchanged |

- Register file writes:
  - opcodes 0-10 write regs[rd], result_wr=1;
  - CMP and NOP do not write, result_wr=0.
- zero_out = (result_out == 0) for every op except NOP, which leaves it unchanged.
- ADC/SBB use the carry flag as it stood before this instruction's edge.
- NOP still produces a result beat.
- dbg_data reflects a write from the cycle after the write edge.

Test Plan:
- Reset then ADD: LDI r1=0xF0, LDI r2=0x20, ADD r3=r1+r2, result_ready=1 -> beats 0xF0, 0x20, then 0x10 with carry_out=1, zero_out=0; dbg r3=0x10.
- Multi-byte chain: ADC r4=r1+r2 immediately after that ADD -> 0x11 (carry in 1), carry_out=1; SBB with A=0x00, B=0x00, carry=1 -> 0xFF, carry_out=1.
- Back-to-back dependency: LDI r1=5; ADD r1=r1+r1; ADD r1=r1+r1 on consecutive cycles -> results 5, 10, 20 with result_valid every cycle.
- Backpressure: hold result_ready=0 for 3 cycles with 3 instructions offered -> two accepted, instr_ready=0 afterwards, result_out stable; release -> results in order, no loss or duplication.
- CMP/NOP: CMP r1(0x07) vs r2(0x07) -> result 0, zero_out=1, result_wr=0, r1 unchanged; then NOP -> flags unchanged, result_wr=0.
- Reset mid-operation: assert rst with S1 and S2 full -> next cycle result_valid=0, instr_ready=1, flags 0, every dbg read returns 0.
